// File: rtl/loader_pkg.sv
// Shared constants for the state loader: opcodes, FSM states, operand lengths.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        OPERAND = 3'd1,
        WRITE   = 3'd2,
        RUN     = 3'd3,
        ERROR   = 3'd4
    } state_t;

    localparam logic [7:0] OP_REG = 8'h01;
    localparam logic [7:0] OP_MEM = 8'h02;
    localparam logic [7:0] OP_GO  = 8'h03;

    // Operand bytes following each opcode
    localparam int REG_OPERAND_LEN = 5;   // index + 4 data bytes
    localparam int MEM_OPERAND_LEN = 8;   // 4 address + 4 data bytes

    // Counter value at which the final operand byte is accepted
    localparam logic [2:0] REG_LAST = 3'(REG_OPERAND_LEN - 1);
    localparam logic [2:0] MEM_LAST = 3'(MEM_OPERAND_LEN - 1);

endpackage

// File: rtl/shift_accum.sv
// Big-endian byte accumulator: each enabled byte shifts in at the bottom,
// so the first byte received ends up in bits [31:24] after four loads.
module shift_accum (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [31:0] q
);

    // Clear has priority over load so a new command always starts from zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= 32'd0;
        end else if (clr) begin
            q <= 32'd0;
        end else if (en) begin
            q <= {q[23:0], din};
        end
    end

endmodule

// File: rtl/state_loader.sv
// Byte-stream loader: decodes REG/MEM/GO commands from a valid/ready byte
// stream, writes the register file or data memory, then releases the CPU.
//
// Handshake: a byte moves only on a cycle where in_valid and in_ready are
// both high at the rising clock edge; in_data is don't-care otherwise, and
// in_valid may drop at any time without disturbing a partial command.
module state_loader
    import loader_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              err,
    output logic [2:0]        dbg_state
);

    state_t      state, state_nx;
    logic [2:0]  cnt;
    logic        is_mem;
    logic [7:0]  idx;
    logic        live;

    logic        xfer;
    logic        last;
    logic        bad;
    logic        commit;
    logic        acc_clr;
    logic        addr_en;
    logic        data_en;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] data_full;
    logic        unused_data_hi;

    assign xfer    = in_valid && in_ready;
    assign last    = (state == OPERAND) && (cnt == (is_mem ? MEM_LAST : REG_LAST));
    assign bad     = is_mem ? (addr_q[1:0] != 2'b00) : ({24'd0, idx} >= 32'(NREGS));
    assign commit  = xfer && last && !bad;
    assign acc_clr = xfer && (state == IDLE);
    assign addr_en = xfer && (state == OPERAND) && is_mem && (cnt < 3'd4);
    assign data_en = xfer && (state == OPERAND) && (is_mem ? (cnt >= 3'd4) : (cnt >= 3'd1));

    // The final data byte is still being shifted in on the commit edge
    assign data_full      = {data_q[23:0], in_data};
    assign unused_data_hi = ^data_q[31:24];

    shift_accum u_addr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (acc_clr),
        .en      (addr_en),
        .din     (in_data),
        .q       (addr_q)
    );

    shift_accum u_data (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (acc_clr),
        .en      (data_en),
        .din     (in_data),
        .q       (data_q)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state decode; RUN and ERROR only leave through reset
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (xfer) begin
                    case (in_data)
                        OP_REG, OP_MEM: state_nx = OPERAND;
                        OP_GO:          state_nx = RUN;
                        default:        state_nx = ERROR;
                    endcase
                end
            end
            OPERAND: if (xfer && last) state_nx = bad ? ERROR : WRITE;
            WRITE:   state_nx = IDLE;
            RUN:     state_nx = RUN;
            ERROR:   state_nx = ERROR;
            default: state_nx = IDLE;
        endcase
    end

    // Moore outputs; in_ready is held low until the first edge after reset
    always_comb begin
        in_ready  = live && ((state == IDLE) || (state == OPERAND));
        rf_we     = (state == WRITE) && !is_mem && (idx != 8'd0);
        mem_we    = (state == WRITE) && is_mem;
        cpu_hold  = (state != RUN);
        err       = (state == ERROR);
        dbg_state = state;
    end

    // Marks the first clock after reset release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) live <= 1'b0;
        else          live <= 1'b1;
    end

    // Command type, register index and operand position counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= 3'd0;
            is_mem <= 1'b0;
            idx    <= 8'd0;
        end else if (xfer) begin
            if (state == IDLE) begin
                cnt    <= 3'd0;
                is_mem <= (in_data == OP_MEM);
            end else if (state == OPERAND) begin
                cnt <= last ? 3'd0 : cnt + 3'd1;
                if (!is_mem && (cnt == 3'd0)) idx <= in_data;
            end
        end
    end

    // Write-port registers update only when a write is committed, so they
    // hold their last values between strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_waddr  <= 5'd0;
            rf_wdata  <= '0;
            mem_addr  <= 32'd0;
            mem_wdata <= '0;
        end else if (commit) begin
            if (is_mem) begin
                mem_addr  <= addr_q;
                mem_wdata <= DATA_W'(data_full);
            end else if (idx != 8'd0) begin
                rf_waddr <= idx[4:0];
                rf_wdata <= DATA_W'(data_full);
            end
        end
    end

endmodule

// File: tb/tb_state_loader.sv
// Directed bench for state_loader with a write scoreboard.
module tb_state_loader;
    import loader_pkg::*;

    localparam int DATA_W = 32;
    localparam int W      = 65;   // {is_mem, addr[31:0], data[31:0]}

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_hold;
    logic              err;
    logic [2:0]        dbg_state;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_got;
    logic [W-1:0] mon_want;
    int n_checks = 0;
    int n_fail   = 0;

    // Clock
    always #5 clk = ~clk;

    state_loader #(.DATA_W(DATA_W), .NREGS(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .err       (err),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (reset_n === 1'b1 && (rf_we === 1'b1 || mem_we === 1'b1)) begin
            mon_got = (mem_we === 1'b1) ? {1'b1, mem_addr, mem_wdata}
                                        : {1'b0, 27'd0, rf_waddr, rf_wdata};
            check("dual_strobe", W'(rf_we & mem_we), W'(0));
            check("strobe_expected", W'(exp_q.size() != 0), W'(1));
            if (exp_q.size() != 0) begin
                mon_want = exp_q.pop_front();
                check("write_value", mon_got, mon_want);
            end
        end
    end

    // Driver: offer one byte from a falling edge and wait for acceptance
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            check("byte_accept_timeout", W'(in_ready), W'(1));
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom_range(0, 255));
    endtask

    // Strobe must appear exactly one cycle after the last byte, for one cycle
    task automatic after_cmd(input string tag, input logic exp_rf, input logic exp_mem);
        @(negedge clk);
        check({tag, "_rf_we"},    W'(rf_we),    W'(exp_rf));
        check({tag, "_mem_we"},   W'(mem_we),   W'(exp_mem));
        check({tag, "_in_ready"}, W'(in_ready), W'(0));
        @(negedge clk);
        check({tag, "_strobe_off"}, W'({rf_we, mem_we}), W'(0));
    endtask

    task automatic send_reg(input string tag, input logic [7:0] idx, input logic [31:0] data,
                            input logic exp_rf);
        if (exp_rf) exp_q.push_back({1'b0, 27'd0, idx[4:0], data});
        send_byte(OP_REG);
        send_byte(idx);
        for (int i = 3; i >= 0; i--) send_byte(data[8*i +: 8]);
        after_cmd(tag, exp_rf, 1'b0);
    endtask

    task automatic send_mem(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic exp_mem);
        if (exp_mem) exp_q.push_back({1'b1, addr, data});
        send_byte(OP_MEM);
        for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8]);
        for (int i = 3; i >= 0; i--) send_byte(data[8*i +: 8]);
        after_cmd(tag, 1'b0, exp_mem);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        #2;
        check({tag, "_state"},     W'(dbg_state), W'(IDLE));
        check({tag, "_in_ready"},  W'(in_ready),  W'(0));
        check({tag, "_cpu_hold"},  W'(cpu_hold),  W'(1));
        check({tag, "_err"},       W'(err),       W'(0));
        check({tag, "_strobes"},   W'({rf_we, mem_we}), W'(0));
        check({tag, "_rf_outs"},   W'({rf_waddr, rf_wdata}), W'(0));
        check({tag, "_mem_outs"},  W'({mem_addr, mem_wdata}), W'(0));
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check({tag, "_ready_held"}, W'(in_ready), W'(0));
        @(negedge clk);
        check({tag, "_ready_rise"}, W'(in_ready), W'(1));
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  ridx;
        logic [31:0] rdat;
        reset_n  = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        do_reset("rst0");

        // REG r2 <- 0x0040000C, CPU stays held
        send_reg("reg2", 8'h02, 32'h0040000C, 1'b1);
        check("reg2_hold", W'(cpu_hold), W'(1));
        check("reg2_waddr_kept", W'(rf_waddr), W'(2));
        check("reg2_wdata_kept", W'(rf_wdata), W'(32'h0040000C));

        // REG r3 <- 0xFFFFFFFF with a 3-cycle stall between data bytes 2 and 3
        exp_q.push_back({1'b0, 27'd0, 5'd3, 32'hFFFFFFFF});
        send_byte(OP_REG);
        send_byte(8'h03);
        send_byte(8'hFF);
        send_byte(8'hFF);
        repeat (3) begin
            @(negedge clk);
            check("stall_state", W'(dbg_state), W'(OPERAND));
            check("stall_no_strobe", W'({rf_we, mem_we}), W'(0));
        end
        send_byte(8'hFF);
        send_byte(8'hFF);
        after_cmd("reg3_stall", 1'b1, 1'b0);

        // Random register writes
        for (int k = 0; k < 3; k++) begin
            ridx = 8'($urandom_range(1, 31));
            rdat = $urandom();
            send_reg("reg_rand", ridx, rdat, 1'b1);
        end

        // r0 is hardwired: handshake completes, no write, no error
        send_reg("reg0", 8'h00, 32'h12345678, 1'b0);
        check("reg0_idle", W'(dbg_state), W'(IDLE));
        check("reg0_err", W'(err), W'(0));

        // Reset in the middle of a REG command discards it
        send_byte(OP_REG);
        send_byte(8'h05);
        send_byte(8'hAA);
        do_reset("rst_mid");
        send_reg("reg7_after_rst", 8'h07, 32'h11223344, 1'b1);

        // MEM write then GO releases the CPU
        send_mem("mem_ok", 32'h00010000, 32'hDEADBEEF, 1'b1);
        check("mem_addr_kept", W'(mem_addr), W'(32'h00010000));
        check("mem_wdata_kept", W'(mem_wdata), W'(32'hDEADBEEF));
        send_byte(OP_GO);
        @(negedge clk);
        check("go_cpu_hold", W'(cpu_hold), W'(0));
        check("go_in_ready", W'(in_ready), W'(0));
        check("go_state", W'(dbg_state), W'(RUN));
        in_valid = 1'b1;
        in_data  = OP_REG;
        repeat (3) @(negedge clk);
        check("run_terminal_ready", W'(in_ready), W'(0));
        check("run_terminal_hold", W'(cpu_hold), W'(0));
        check("run_terminal_state", W'(dbg_state), W'(RUN));
        in_valid = 1'b0;

        // Illegal opcode -> sticky error
        do_reset("rst_badop");
        send_byte(8'h7F);
        @(negedge clk);
        check("badop_err", W'(err), W'(1));
        check("badop_ready", W'(in_ready), W'(0));
        check("badop_hold", W'(cpu_hold), W'(1));
        in_valid = 1'b1;
        in_data  = OP_GO;
        repeat (4) @(negedge clk);
        check("badop_err_sticky", W'(err), W'(1));
        check("badop_ready_sticky", W'(in_ready), W'(0));
        in_valid = 1'b0;

        // Misaligned memory address -> error, no write
        do_reset("rst_misalign");
        send_mem("mem_misalign", 32'h00010002, 32'hCAFEF00D, 1'b0);
        check("misalign_err", W'(err), W'(1));
        check("misalign_mem_addr", W'(mem_addr), W'(0));

        // Register index out of range -> error, no write
        do_reset("rst_idx");
        send_reg("reg_idx32", 8'h20, 32'h0BADF00D, 1'b0);
        check("idx32_err", W'(err), W'(1));
        check("idx32_rf_outs", W'({rf_waddr, rf_wdata}), W'(0));

        repeat (2) @(negedge clk);
        check("scoreboard_drained", W'(exp_q.size()), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
